// File: rtl/sdram_burst_writer.sv
// sdram_burst_writer: packs RGB pixels into DATA_W words and writes whole frames to SDRAM as Avalon-MM bursts.
// Define SDRAM_BURST_WRITER_SLOTSWAP_EN to place the first pixel of a word in the most-significant slot.
module sdram_burst_writer #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 29,
  parameter int BURST_LEN  = 32,
  parameter int NUM_BUF    = 2,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                      clk_100,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      start_frame,
  input  logic [7:0]                r_fb,
  input  logic [7:0]                g_fb,
  input  logic [7:0]                b_fb,
  input  logic                      data_fb_valid,
  input  logic [23:0]               frame_words,
  input  logic [NUM_BUF*ADDR_W-1:0] buf_addr,
  output logic [1:0]                cur_buf,
  output logic                      end_frame,
  output logic                      busy,
  output logic [15:0]               drop_cnt,
  output logic [ADDR_W-1:0]         avl_address,
  output logic                      avl_write,
  output logic [DATA_W-1:0]         avl_writedata,
  output logic [DATA_W/8-1:0]       avl_byteenable,
  output logic [7:0]                avl_burstcount,
  input  logic                      avl_waitrequest
);
  localparam int P  = DATA_W / 32;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_BURST, S_FLUSH} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr, r_rd;
  logic [AW:0]         r_count;
  logic [15:0]         r_drop;
  logic [DATA_W-33:0]  r_pack;
  logic [2:0]          r_slot;
  logic [23:0]         r_in_left, r_rem;
  logic [7:0]          r_beat, r_bc;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_cur_buf;
  logic                r_write, r_busy, r_end_frame, r_abort, r_started;

  logic [31:0]         w_slot;
  logic [DATA_W-1:0]   w_word;
  logic [ADDR_W-1:0]   w_base [4];
  logic [1:0]          w_next_buf;
  logic [23:0]         w_fw;
  logic [7:0]          w_min;
  logic                w_load, w_acc, w_done, w_full, w_push, w_pop;

  for (genvar i = 0; i < 4; i++) begin : g_base
    if (i < NUM_BUF) begin : g_on
      assign w_base[i] = buf_addr[i*ADDR_W +: ADDR_W];
    end else begin : g_off
      assign w_base[i] = '0;
    end
  end

  assign w_slot = {8'd0, b_fb, g_fb, r_fb};
`ifdef SDRAM_BURST_WRITER_SLOTSWAP_EN
  assign w_word = {r_pack, w_slot};
`else
  assign w_word = {w_slot, r_pack};
`endif

  assign w_next_buf = (!r_started || r_cur_buf == 2'(NUM_BUF - 1)) ? 2'd0 : r_cur_buf + 2'd1;
  assign w_fw       = (frame_words == 24'd0) ? 24'd1 : frame_words;
  assign w_min      = (r_rem < 24'(BURST_LEN)) ? r_rem[7:0] : 8'(BURST_LEN);
  assign w_load     = (r_state == S_IDLE && start_frame && enable) || (r_state == S_FLUSH && r_count == '0);
  assign w_acc      = data_fb_valid && r_in_left != 24'd0 &&
                      (r_state == S_ARM || r_state == S_WAIT || r_state == S_BURST);
  assign w_done     = w_acc && r_slot == 3'(P - 1);
  assign w_full     = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_push     = w_done && !w_full;
  assign w_pop      = (r_state == S_BURST && !avl_waitrequest) || (r_state == S_FLUSH && r_count != '0);

  assign cur_buf        = r_cur_buf;
  assign end_frame      = r_end_frame;
  assign busy           = r_busy;
  assign drop_cnt       = r_drop;
  assign avl_address    = r_addr;
  assign avl_write      = r_write;
  assign avl_burstcount = r_bc;
  assign avl_byteenable = '1;
  assign avl_writedata  = r_write ? r_mem[r_rd] : '0;

  always_ff @(posedge clk_100)
    if (w_push) r_mem[r_wr] <= w_word;

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_done && w_full && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end

  // The packer keeps the P-1 earlier slots; the word is pushed as the P-th slot arrives.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      r_pack    <= '0;
      r_slot    <= '0;
      r_in_left <= '0;
    end else if (w_load) begin
      r_slot    <= '0;
      r_in_left <= w_fw;
    end else if (w_acc) begin
`ifdef SDRAM_BURST_WRITER_SLOTSWAP_EN
      r_pack    <= w_word[DATA_W-33:0];
`else
      r_pack    <= w_word[DATA_W-1:32];
`endif
      r_slot    <= w_done ? 3'd0 : r_slot + 3'd1;
      r_in_left <= r_in_left - 24'(w_done);
    end
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cur_buf   <= '0;
      r_started   <= 1'b0;
      r_addr      <= '0;
      r_rem       <= '0;
      r_bc        <= '0;
      r_beat      <= '0;
      r_write     <= 1'b0;
      r_busy      <= 1'b0;
      r_end_frame <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_end_frame <= 1'b0;
      if (w_load) begin
        r_state   <= S_ARM;
        r_cur_buf <= w_next_buf;
        r_started <= 1'b1;
        r_addr    <= w_base[w_next_buf];
        r_rem     <= w_fw;
        r_busy    <= 1'b1;
        r_abort   <= 1'b0;
      end else begin
        case (r_state)
          S_ARM: r_state <= S_WAIT;
          S_WAIT:
            if (start_frame) r_state <= S_FLUSH;
            else if (32'(r_count) >= 32'(w_min)) begin
              r_state <= S_BURST;
              r_write <= 1'b1;
              r_bc    <= w_min;
            end
          S_BURST: begin
            if (start_frame) r_abort <= 1'b1;
            // An abort request lets the burst finish, then the rest of the frame is flushed.
            if (!avl_waitrequest && r_beat == r_bc - 8'd1) begin
              r_write <= 1'b0;
              r_beat  <= '0;
              r_addr  <= r_addr + ADDR_W'(r_bc);
              r_rem   <= r_rem - 24'(r_bc);
              if (r_abort || start_frame) r_state <= S_FLUSH;
              else if (r_rem == 24'(r_bc)) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_end_frame <= 1'b1;
              end else r_state <= S_WAIT;
            end else if (!avl_waitrequest) r_beat <= r_beat + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sdram_burst_writer.sv
// tb_sdram_burst_writer: directed frames with a scoreboard of expected Avalon beats checked by a monitor.
module tb_sdram_burst_writer;
  localparam logic [28:0] B0 = 29'h0000_1000;
  localparam logic [28:0] B1 = 29'h0020_0000;
  localparam logic [28:0] B2 = 29'h1FFF_FFF0;

  typedef struct packed {logic [28:0] a; logic [7:0] bc; logic [63:0] d;} beat_t;

  logic        clk_100 = 1'b0, reset = 1'b1, enable = 1'b0, start_frame = 1'b0;
  logic [7:0]  r_fb = '0, g_fb = '0, b_fb = '0;
  logic        data_fb_valid = 1'b0, avl_waitrequest = 1'b0;
  logic [23:0] frame_words = 24'd64;
  logic [86:0] buf_addr = {B2, B1, B0};
  logic [1:0]  cur_buf;
  logic        end_frame, busy, avl_write;
  logic [15:0] drop_cnt;
  logic [28:0] avl_address;
  logic [63:0] avl_writedata;
  logic [7:0]  avl_byteenable, avl_burstcount;

  beat_t exp_q[$];
  int checks = 0, failures = 0, ef_cnt = 0, nbeats = 0;

  sdram_burst_writer #(.DATA_W(64), .ADDR_W(29), .BURST_LEN(32), .NUM_BUF(3), .FIFO_DEPTH(64)) dut (
    .clk_100(clk_100), .reset(reset), .enable(enable), .start_frame(start_frame),
    .r_fb(r_fb), .g_fb(g_fb), .b_fb(b_fb), .data_fb_valid(data_fb_valid),
    .frame_words(frame_words), .buf_addr(buf_addr), .cur_buf(cur_buf),
    .end_frame(end_frame), .busy(busy), .drop_cnt(drop_cnt),
    .avl_address(avl_address), .avl_write(avl_write), .avl_writedata(avl_writedata),
    .avl_byteenable(avl_byteenable), .avl_burstcount(avl_burstcount),
    .avl_waitrequest(avl_waitrequest));

  initial forever #5 clk_100 = ~clk_100;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial begin
    logic        prev_stall = 1'b0;
    logic [28:0] pa;
    logic [7:0]  pb;
    logic [63:0] pd;
    beat_t       e;
    forever begin
      @(negedge clk_100);
      if (reset) prev_stall = 1'b0;
      else begin
        if (end_frame) ef_cnt++;
        if (avl_write) begin
          if (prev_stall) begin
            chk("hold_addr", 64'(avl_address), 64'(pa));
            chk("hold_bc", 64'(avl_burstcount), 64'(pb));
            chk("hold_data", avl_writedata, pd);
          end
          if (!avl_waitrequest) begin
            if (exp_q.size() == 0) chk("unexpected_beat_addr", 64'(avl_address), 64'h1_0000_0000);
            else begin
              e = exp_q.pop_front();
              chk("beat_addr", 64'(avl_address), 64'(e.a));
              chk("beat_bc", 64'(avl_burstcount), 64'(e.bc));
              chk("beat_data", avl_writedata, e.d);
            end
            nbeats++;
          end
          prev_stall = avl_waitrequest;
          pa = avl_address;
          pb = avl_burstcount;
          pd = avl_writedata;
        end else prev_stall = 1'b0;
      end
    end
  end

  task automatic start_pulse(input logic en);
    @(posedge clk_100); #1;
    enable = en;
    start_frame = 1'b1;
    @(posedge clk_100); #1;
    start_frame = 1'b0;
  endtask

  task automatic send(input int n, input int fw, input int n_keep, input logic [23:0] seed,
                      input logic [23:0] step, input logic [28:0] base);
    logic [23:0] px, prv;
    beat_t e;
    int bi;
    prv = '0;
    for (int i = 0; i < n; i++) begin
      px = seed + step * 24'(i);
      {b_fb, g_fb, r_fb} = px;
      data_fb_valid = 1'b1;
      if (i % 2 == 1 && i / 2 < n_keep) begin
        bi = (i / 2 / 32) * 32;
        e.a = base + 29'(bi);
        e.bc = 8'((fw - bi < 32) ? fw - bi : 32);
`ifdef SDRAM_BURST_WRITER_SLOTSWAP_EN
        e.d = {8'd0, prv, 8'd0, px};
`else
        e.d = {8'd0, px, 8'd0, prv};
`endif
        exp_q.push_back(e);
      end
      prv = px;
      @(posedge clk_100); #1;
    end
    data_fb_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 3000 && busy; k++) begin
      @(posedge clk_100); #1;
    end
    chk(nm, 64'(busy), 64'd0);
    repeat (2) @(posedge clk_100);
    #1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t h;
    repeat (3) @(posedge clk_100);
    #1;
    chk("rst_write", 64'(avl_write), 64'd0);
    chk("rst_addr", 64'(avl_address), 64'd0);
    chk("rst_bc", 64'(avl_burstcount), 64'd0);
    chk("rst_data", avl_writedata, 64'd0);
    chk("rst_cur_buf", 64'(cur_buf), 64'd0);
    chk("rst_end_frame", 64'(end_frame), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("byteenable", 64'(avl_byteenable), 64'hFF);
    reset = 1'b0;

    // 64 words in two full bursts into buffer 0
    start_pulse(1'b1);
    chk("f1_cur_buf", 64'(cur_buf), 64'd0);
    chk("f1_busy", 64'(busy), 64'd1);
    send(128, 64, 64, 24'h010000, 24'd1, B0);
    wait_idle("f1_idle");
    chk("f1_end_frame", 64'(ef_cnt), 64'd1);
    chk("f1_beats", 64'(nbeats), 64'd64);

    // 40 words (32 + 8) with a 10-cycle stall and surplus pixels
    frame_words = 24'd40;
    start_pulse(1'b1);
    chk("f2_cur_buf", 64'(cur_buf), 64'd1);
    fork
      send(84, 40, 40, 24'h020000, 24'd1, B1);
      begin
        for (int k = 0; k < 500 && !avl_write; k++) begin
          @(posedge clk_100); #1;
        end
        repeat (5) @(posedge clk_100);
        #1 avl_waitrequest = 1'b1;
        repeat (10) @(posedge clk_100);
        #1 avl_waitrequest = 1'b0;
      end
    join
    wait_idle("f2_idle");
    chk("f2_end_frame", 64'(ef_cnt), 64'd2);
    chk("f2_beats", 64'(nbeats), 64'd104);
    chk("f2_q_empty", 64'(exp_q.size()), 64'd0);

    // buffer 2 sits at the top of the address space, so the second burst wraps
    start_pulse(1'b1);
    chk("f3_cur_buf", 64'(cur_buf), 64'd2);
    send(80, 40, 40, 24'h030000, 24'd1, B2);
    wait_idle("f3_idle");
    chk("f3_end_frame", 64'(ef_cnt), 64'd3);
    chk("f3_beats", 64'(nbeats), 64'd144);

    start_pulse(1'b0);
    repeat (3) @(posedge clk_100);
    #1;
    chk("f4_disabled_busy", 64'(busy), 64'd0);
    chk("f4_disabled_buf", 64'(cur_buf), 64'd2);

    // stalled slave lets the FIFO overflow, then the frame is aborted
    frame_words = 24'd100;
    avl_waitrequest = 1'b1;
    start_pulse(1'b1);
    chk("f5_cur_buf", 64'(cur_buf), 64'd0);
    send(138, 100, 32, 24'h050000, 24'd1, B0);
    repeat (5) @(posedge clk_100);
    #1;
    chk("f5_drop_cnt", 64'(drop_cnt), 64'd5);
    chk("f5_stalled_write", 64'(avl_write), 64'd1);
    frame_words = 24'd0;
    start_pulse(1'b1);
    avl_waitrequest = 1'b0;
    for (int k = 0; k < 500 && cur_buf != 2'd1; k++) begin
      @(posedge clk_100); #1;
    end
    chk("f5_next_buf", 64'(cur_buf), 64'd1);
    chk("f5_busy", 64'(busy), 64'd1);
    chk("f5_no_end_frame", 64'(ef_cnt), 64'd3);
    chk("f5_beats", 64'(nbeats), 64'd176);

    // frame_words=0 acts as one word; later pixels are ignored
    h.a = B1;
    h.bc = 8'd1;
`ifdef SDRAM_BURST_WRITER_SLOTSWAP_EN
    h.d = 64'h00000011_00000022;
`else
    h.d = 64'h00000022_00000011;
`endif
    exp_q.push_back(h);
    send(8, 1, 0, 24'h000011, 24'h000011, B1);
    wait_idle("f6_idle");
    chk("f6_end_frame", 64'(ef_cnt), 64'd4);
    chk("f6_beats", 64'(nbeats), 64'd177);
    chk("f6_q_empty", 64'(exp_q.size()), 64'd0);
    chk("f6_drop_cnt", 64'(drop_cnt), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdram_burst_writer.md
SDRAM_BURST_WRITER -- requirements
Module: sdram_burst_writer

Interface
REQ-001 SHALL provide parameter DATA_W, 64, Avalon writedata width in bits; multiple of 32, 64..256.
REQ-002 SHALL provide parameter ADDR_W, 29, Avalon word address width.
REQ-003 SHALL provide parameter BURST_LEN, 32, maximum beats per burst; 1..128.
REQ-004 SHALL provide parameter NUM_BUF, 2, frame buffers rotated per frame; 1..4.
REQ-005 SHALL provide parameter FIFO_DEPTH, 256, packed-word FIFO depth; power of 2, at least 2*BURST_LEN.
REQ-006 SHALL have one clock; reset is asynchronous and active-high.
REQ-007 SHALL provide ports:
- clk_100  in  1  sole clock
- reset  in  1  asynchronous active-high reset
- enable  in  1  arms writing; sampled only at start_frame
- start_frame  in  1  one-cycle frame-start pulse
- r_fb, g_fb, b_fb  in  8 each  pixel components
- data_fb_valid  in  1  pixel strobe
- frame_words  in  24  DATA_W words per frame; 0 is treated as 1
- buf_addr  in  NUM_BUF*ADDR_W  base word address per buffer; buffer k at slice k
- cur_buf  out  2  buffer index being written
- end_frame  out  1  one-cycle pulse when the last frame beat is accepted
- busy  out  1  frame in progress
- drop_cnt  out  16  dropped-word count, saturating
- avl_address  out  ADDR_W  burst start address
- avl_write  out  1  write request
- avl_writedata  out  DATA_W  write data
- avl_byteenable  out  DATA_W/8  held all-ones
- avl_burstcount  out  8  beats in current burst
- avl_waitrequest  in  1  slave stall

Function
REQ-008 Each valid pixel SHALL form a 32-bit slot {8'd0, b, g, r}; P = DATA_W/32 slots SHALL pack into one word, written to the FIFO on the cycle the P-th slot arrives.
REQ-009 A packed word arriving while the FIFO is full SHALL be dropped, and drop_cnt SHALL increment, saturating at 16'hFFFF.
REQ-010 The FSM SHALL have states IDLE, ARM, WAIT, BURST, FLUSH.
REQ-011 IDLE->ARM on start_frame with enable=1: cur_buf advances modulo NUM_BUF (the first frame after reset uses buffer 0), address loads buf_addr[cur_buf], remaining loads frame_words, the packer clears, busy=1.
REQ-012 ARM->WAIT after one cycle; pixels during ARM SHALL be accepted.
REQ-013 WAIT->BURST when FIFO count >= min(BURST_LEN, remaining); burstcount SHALL be latched to that minimum.
REQ-014 In BURST, avl_write=1; a beat completes when avl_waitrequest=0; address, burstcount and writedata SHALL be held while stalled; the FIFO SHALL pop only on accepted beats.
REQ-015 After the last beat, address SHALL advance by burstcount and remaining SHALL decrement by burstcount; if remaining reaches 0: end_frame pulse, ->IDLE, busy=0; otherwise ->WAIT.
REQ-016 Pixels beyond frame_words*P in a frame SHALL be ignored (not written to the FIFO, not counted as drops).
REQ-017 start_frame during WAIT SHALL go to FLUSH; start_frame during BURST SHALL complete the current burst, then go to FLUSH; no end_frame is issued for the aborted frame.
REQ-018 FLUSH SHALL empty the FIFO without Avalon writes, then enter ARM with the REQ-011 loads applied; pixels during FLUSH SHALL be discarded.
REQ-019 start_frame with enable=0 SHALL leave the FSM in IDLE, and cur_buf SHALL stay unchanged.
REQ-020 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-021 Simultaneous FIFO push and pop SHALL leave the FIFO count unchanged.

Reset
REQ-022 Reset SHALL force IDLE, empty the FIFO, and clear the packer; avl_write, avl_address, avl_burstcount, avl_writedata, cur_buf, end_frame, busy and drop_cnt SHALL all be 0.
REQ-023 Reset asserted mid-burst SHALL abandon the burst immediately; the frame SHALL NOT be resumed after reset.

Configuration
REQ-024 With SDRAM_BURST_WRITER_SLOTSWAP_EN defined, the first pixel of a word SHALL occupy the most-significant 32-bit slot of avl_writedata; undefined, the first pixel SHALL occupy bits [31:0].

Verification
REQ-025 DATA_W=64, BURST_LEN=32, frame_words=64, 128 back-to-back pixels -> two bursts of burstcount 32 at base and base+32, then one end_frame pulse.
REQ-026 frame_words=40 -> bursts of 32 and 8; the second burst is at base+32; end_frame follows its 8th beat.
REQ-027 NUM_BUF=3, four enabled frames -> cur_buf sequence 0,1,2,0; each frame's first address equals buf_addr slice.
REQ-028 avl_waitrequest held high 10 cycles mid-burst -> address, burstcount and data stable; no FIFO pop; beat count exactly 32.
REQ-029 Waitrequest held high until the FIFO fills, then 5 more words -> drop_cnt=5; start_frame mid-frame -> FLUSH, no end_frame, new frame starts at the next buffer.
REQ-030 Pixels 0x11,0x22 with SLOTSWAP_EN undefined -> writedata 64'h00000022_00000011; with it defined -> 64'h00000011_00000022.
